// File: rtl/encoder_rr_reg.sv
// Registered N-to-log2(N) request encoder with fixed-priority or round-robin selection,
// valid/ready on both sides, and zero / multiple-hot status flags.
module encoder_rr_reg #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_idx,
    output logic         out_zero,
    output logic         out_multi,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] ptr;
    logic [N-1:0] above;
    logic [N-1:0] req_hi;
    logic [W-1:0] win_idx;
    logic [W-1:0] nxt_ptr;
    logic         req_zero;
    logic         req_multi;
    logic         accept;

    function automatic logic [W-1:0] lowest(input logic [N-1:0] v);
        lowest = '0;
        for (int i = N - 1; i >= 0; i--)
            if (v[i]) lowest = W'(i);
    endfunction

    // Round-robin searches the lines at or above ptr first, then wraps to the full vector.
    always_comb begin
        above = '0;
        for (int i = 0; i < N; i++)
            above[i] = (i >= int'(ptr));
        req_hi    = req & above;
        win_idx   = (mode && |req_hi) ? lowest(req_hi) : lowest(req);
        nxt_ptr   = (win_idx == W'(N - 1)) ? '0 : win_idx + W'(1);
        req_zero  = ~|req;
        req_multi = (req & (req - {{(N-1){1'b0}}, 1'b1})) != '0;
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_zero  <= 1'b0;
            out_multi <= 1'b0;
            ptr       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_idx   <= win_idx;
            out_zero  <= req_zero;
            out_multi <= req_multi;
            if (mode && !req_zero) ptr <= nxt_ptr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_encoder_rr_reg.sv
// Bench for encoder_rr_reg: N=8 and N=5 instances against a queue-free behavioural model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_encoder_rr_reg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iv[2];
    logic       ordy[2];
    logic       md[2];
    logic [7:0] rq[2];
    logic       ir[2];
    logic [2:0] oi[2];
    logic       oz[2];
    logic       om[2];
    logic       ov[2];

    int pass_cnt = 0;
    int total_cnt = 0;

    // model state, one slot per DUT
    int ev[2];
    int eidx[2];
    int ezero[2];
    int emulti[2];
    int eptr[2];

    always #5 clk = ~clk;

    encoder_rr_reg #(.N(8)) d8 (
        .clk(clk), .rst_n(rst_n), .req(rq[0]), .mode(md[0]), .in_valid(iv[0]),
        .in_ready(ir[0]), .out_idx(oi[0]), .out_zero(oz[0]), .out_multi(om[0]),
        .out_valid(ov[0]), .out_ready(ordy[0])
    );

    encoder_rr_reg #(.N(5)) d5 (
        .clk(clk), .rst_n(rst_n), .req(rq[1][4:0]), .mode(md[1]), .in_valid(iv[1]),
        .in_ready(ir[1]), .out_idx(oi[1]), .out_zero(oz[1]), .out_multi(om[1]),
        .out_valid(ov[1]), .out_ready(ordy[1])
    );

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int nlines(input int d);
        return (d == 0) ? 8 : 5;
    endfunction

    // scan lines starting at the search origin, wrapping once around
    function automatic int winner(input int n, input int r, input int p, input bit m);
        int start;
        start = m ? p : 0;
        for (int k = 0; k < n; k++)
            if (r[(start + k) % n]) return (start + k) % n;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                ev[d] <= 0; eidx[d] <= 0; ezero[d] <= 0; emulti[d] <= 0; eptr[d] <= 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                int n, r, w;
                n = nlines(d);
                r = int'(rq[d]) & ((1 << n) - 1);
                w = winner(n, r, eptr[d], md[d]);
                if (iv[d] && (ev[d] == 0 || ordy[d])) begin
                    ev[d]     <= 1;
                    eidx[d]   <= w;
                    ezero[d]  <= (r == 0);
                    emulti[d] <= ($countones(r) >= 2);
                    if (md[d] && r != 0) eptr[d] <= (w + 1) % n;
                end else if (ordy[d]) begin
                    ev[d] <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            check($sformatf("in_ready[%0d]", d), int'(ir[d]), (ev[d] == 0 || ordy[d]) ? 1 : 0);
            check($sformatf("out_valid[%0d]", d), int'(ov[d]), ev[d]);
            if (ev[d] != 0) begin
                check($sformatf("out_idx[%0d]", d), int'(oi[d]), eidx[d]);
                check($sformatf("out_zero[%0d]", d), int'(oz[d]), ezero[d]);
                check($sformatf("out_multi[%0d]", d), int'(om[d]), emulti[d]);
            end
        end
    end

    task automatic xfer(input int d, input bit m, input logic [7:0] r);
        iv[d] = 1'b1; md[d] = m; rq[d] = r;
        @(posedge clk); #1;
        iv[d] = 1'b0;
    endtask

    task automatic lit(input string name, input int d, input int idx, input int z, input int mh);
        check({name, ".valid"}, int'(ov[d]), 1);
        check({name, ".idx"}, int'(oi[d]), idx);
        check({name, ".zero"}, int'(oz[d]), z);
        check({name, ".multi"}, int'(om[d]), mh);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b1; md[d] = 1'b0; rq[d] = '0;
        end
        #1;
        check("rst.in_ready", int'(ir[0]), 1);
        check("rst.out_valid", int'(ov[0]), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("post_rst.in_ready5", int'(ir[1]), 1);
        check("post_rst.out_valid5", int'(ov[1]), 0);

        // fixed priority
        xfer(0, 1'b0, 8'b0010_1000); lit("fix_a", 0, 3, 0, 1);
        xfer(0, 1'b0, 8'b1000_0000); lit("fix_b", 0, 7, 0, 0);

        // round-robin sweep
        for (int k = 0; k < 9; k++) begin
            xfer(0, 1'b1, 8'hFF);
            lit($sformatf("rr%0d", k), 0, k % 8, 0, 1);
        end
        xfer(0, 1'b1, 8'b0000_0101); lit("rr_wrap", 0, 2, 0, 1);

        // backpressure: held result 2, pending request would give 3
        ordy[0] = 1'b0; iv[0] = 1'b1; md[0] = 1'b1; rq[0] = 8'hFF;
        repeat (3) begin
            @(posedge clk); #1;
            check("bp.in_ready", int'(ir[0]), 0);
            lit("bp.hold", 0, 2, 0, 1);
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        lit("bp.release", 0, 3, 0, 1);

        // zero input and mode switching around ptr=5
        xfer(0, 1'b1, 8'b0001_0000); lit("to_ptr5", 0, 4, 0, 0);
        xfer(0, 1'b1, 8'h00);        lit("zero", 0, 0, 1, 0);
        xfer(0, 1'b0, 8'hFF);        lit("fix_mid", 0, 0, 0, 1);
        xfer(0, 1'b1, 8'hFF);        lit("rr_resume", 0, 5, 0, 1);

        // non-power-of-two wrap
        xfer(1, 1'b1, 8'b0001_1000); lit("n5_a", 1, 3, 0, 1);
        xfer(1, 1'b1, 8'b0001_1000); lit("n5_b", 1, 4, 0, 1);
        xfer(1, 1'b1, 8'b0000_0011); lit("n5_c", 1, 0, 0, 1);

        // asynchronous reset while a result is held
        xfer(0, 1'b1, 8'hFF);
        ordy[0] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst.out_valid", int'(ov[0]), 0);
        check("arst.out_idx", int'(oi[0]), 0);
        check("arst.out_multi", int'(om[0]), 0);
        check("arst.in_ready", int'(ir[0]), 1);
        ordy[0] = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;
        xfer(0, 1'b1, 8'hFF); lit("arst.first", 0, 0, 0, 1);

        // randomized traffic on both instances
        for (int c = 0; c < 600; c++) begin
            for (int d = 0; d < 2; d++) begin
                int sel;
                sel = $urandom_range(0, 5);
                iv[d]   = ($urandom_range(0, 3) != 0);
                ordy[d] = ($urandom_range(0, 3) != 0);
                md[d]   = $urandom_range(0, 1);
                if (sel == 0) rq[d] = 8'h00;
                else if (sel == 1) rq[d] = 8'(1 << $urandom_range(0, nlines(d) - 1));
                else rq[d] = 8'($urandom);
                if (d == 1) rq[d][7:5] = 3'b000;
            end
            @(posedge clk); #1;
        end
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/encoder_rr_reg.md
# encoder_rr_reg

Parametrised, registered N-to-log2(N) request encoder with selectable fixed-priority or round-robin arbitration. It has valid/ready handshakes on both sides. It generalises our 4-to-2 one-hot encoder: inputs may carry any number of set bits, and the result reports the winning index plus zero and multiple-hot status flags. It sits between request sources (interrupt lines, channel requests) and a downstream consumer that accepts one grant index per transfer.

## Interface
- N, default 8, number of request lines; legal range N >= 2, need not be a power of two.
- W, default $clog2(N), width of the index output; derived, not overridden.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request vector, bit i = line i.
- mode  input  1  0 = fixed priority (lowest index wins), 1 = round-robin; sampled with req.
- in_valid  input  1  req/mode are valid this cycle.
- in_ready  output  1  block accepts req/mode this cycle.
- out_idx  output  W  encoded winning index.
- out_zero  output  1  accepted req was all-zero.
- out_multi  output  1  accepted req had more than one bit set.
- out_valid  output  1  out_idx/flags are valid.
- out_ready  input  1  consumer accepts the output this cycle.

## Operation
Single output register stage.
- **Ready:** in_ready = !out_valid || out_ready (combinational).
- **Accept:** occurs on a clk edge with in_valid && in_ready. On accept:
  - out_valid <= 1.
  - out_idx, out_zero and out_multi are loaded from the sampled req/mode.
- **Drain:** out_valid <= 0 on an edge with out_valid && out_ready and no simultaneous accept.
- **Hold:** with out_valid=1 and out_ready=0, all outputs are held stable.
- **Fixed mode (mode=0):** out_idx = lowest set bit index of req. The pointer is untouched.
- **Round-robin mode (mode=1):**
  - Internal pointer ptr (W bits, range 0..N-1).
  - out_idx = lowest set bit at index >= ptr. If there is none, the lowest set bit overall (wrap).
  - After an accept with req != 0, ptr <= out_idx+1, wrapping to 0 when out_idx = N-1. This holds for non-power-of-two N.
- **Zero input:** req = 0 gives out_idx = 0, out_zero = 1, out_multi = 0. ptr is unchanged in either mode.
- **Multiple-hot flag:** out_multi = 1 iff popcount(req) >= 2. It is independent of mode.
- **Mode switching:** mode may change per transfer. Fixed-mode transfers neither use nor modify ptr. A later round-robin transfer resumes from the retained ptr.
- **Out-of-range index:** no index outside 0..N-1 is ever produced.

## Timing
- Latency: 1 cycle from accept edge to out_valid/out_idx.
- Throughput: 1 transfer/cycle while out_ready = 1.
- Simultaneous drain and accept on the same edge: the new result is loaded and out_valid stays 1 (no bubble).
- Reset, asynchronous on rst_n low:
  - out_valid = 0, out_idx = 0, out_zero = 0, out_multi = 0, ptr = 0.
  - in_ready = 1 immediately, because it is combinational on out_valid.
- Reset mid-transfer discards any held output. There is no replay. The first post-reset accept uses ptr = 0.
- No combinational path from req/mode to outputs. The only combinational path is out_ready -> in_ready.

## Test plan
- **Reset:** assert rst_n=0 asynchronously mid-cycle with out_valid=1 -> outputs and ptr go to zero without waiting for clk; after release, in_ready=1 and out_valid=0.
- **Fixed mode:** N=8, mode=0, req=8'b0010_1000 -> next cycle out_idx=3, out_multi=1, out_zero=0; req=8'b1000_0000 -> out_idx=7, out_multi=0.
- **Round-robin sequence:** N=8, mode=1, req=8'hFF for 9 back-to-back transfers, out_ready=1 -> out_idx=0,1,2,3,4,5,6,7,0; then req=8'b0000_0101 with ptr=1 -> out_idx=2.
- **Backpressure:** out_valid=1, out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_idx stable, no accept. Then out_ready=1 -> drain and new accept on the same edge, out_valid stays 1.
- **Zero input and mode switch:** mode=1, ptr=5, req=0 -> out_zero=1, out_idx=0, ptr stays 5. Then mode=0, req=8'hFF -> out_idx=0, ptr stays 5. Then mode=1, req=8'hFF -> out_idx=5.
- **Non-power-of-two wrap:** N=5, mode=1, req=5'b11000 -> out_idx=3; then out_idx=4; then req=5'b00011 -> out_idx=0 (ptr wraps from 5 to 0).
